// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - WIDTH-bit add/subtract computed one nibble per clock
// A single 4-bit ripple slice is reused across the operand, LSB nibble first, carry registered between nibbles.

module nibble_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    co = c[4];
  end

endmodule

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = WIDTH / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [3:0] a_nib, b_nib, slice_sum;
  logic       slice_co;

  // Operand nibble select for the current step k.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  nibble_slice u_slice (
    .a  (a_nib),
    .b  (b_nib),
    .ci (carry_q),
    .s  (slice_sum),
    .co (slice_co)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          // Subtraction is A + ~B + 1, so c_in is dropped in favour of the forced 1.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : c_in;
          k_d     = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        for (int i = 0; i < N; i++) begin
          if (k_q == KW'(i)) begin
            sum_d[4*i +: 4] = slice_sum;
          end
        end
        carry_d = slice_co;
        if (k_q == K_LAST) begin
          // slice_sum[3] is result bit WIDTH-1, so a^b^s recovers the carry into the MSB.
          c_out_d = slice_co;
          ovf_d   = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_sum[3] ^ slice_co;
          k_d     = '0;
          state_d = S_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      S_DONE: begin
        if (result_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign start_ready  = (state_q == S_IDLE) && !rst;
  assign result_valid = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign sum          = sum_q;
  assign c_out        = c_out_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - self-checking bench for nibble_serial_adder
// Directed and random operations checked against an arithmetic reference model.

module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic             clk;
  logic             rst;
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             c_in;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             busy;

  int n_assert;
  int n_fail;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .sub          (sub),
    .c_in         (c_in),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .sum          (sum),
    .c_out        (c_out),
    .ovf          (ovf),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain wide addition, overflow from operand/result signs.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic s, input logic ci);
    logic [WIDTH-1:0] yy;
    logic [WIDTH:0]   t;
    logic             o;
    yy = s ? ~y : y;
    t  = {1'b0, x} + {1'b0, yy} + {{WIDTH{1'b0}}, (s ? 1'b1 : ci)};
    o  = (x[WIDTH-1] == yy[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
    return {t[WIDTH], o, t[WIDTH-1:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                          input logic xs, input logic xc);
    int waited;
    waited = 0;
    while (!start_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("start_ready_wait", {31'd0, start_ready}, 32'd1);
    start_valid = 1'b1;
    a = xa; b = xb; sub = xs; c_in = xc;
    @(negedge clk);
    start_valid = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  // Called in the cycle after acceptance; scrambles all inputs while the op runs.
  task automatic wait_result(input string tag, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                             input logic xs, input logic xc);
    int cycles;
    logic [WIDTH+1:0] exp;
    exp = model(xa, xb, xs, xc);
    cycles = 0;
    while (!result_valid && cycles < 50) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      sub = 1'($urandom); c_in = 1'($urandom);
      start_valid = 1'($urandom); result_ready = 1'($urandom);
      @(negedge clk);
      cycles++;
    end
    start_valid = 1'b0;
    result_ready = 1'b0;
    check({tag, "_latency"}, cycles, N);
    check({tag, "_sum"}, {16'd0, sum}, {16'd0, exp[WIDTH-1:0]});
    check({tag, "_c_out"}, {31'd0, c_out}, {31'd0, exp[WIDTH+1]});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp[WIDTH]});
  endtask

  task automatic finish_op();
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("rv_after_handshake", {31'd0, result_valid}, 32'd0);
    check("sr_after_handshake", {31'd0, start_ready}, 32'd1);
  endtask

  task automatic op(input string tag, input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb,
                    input logic xs, input logic xc);
    start_op(xa, xb, xs, xc);
    wait_result(tag, xa, xb, xs, xc);
    finish_op();
  endtask

  initial begin
    logic [WIDTH-1:0] hold_sum;
    logic             hold_co;
    logic             hold_ovf;
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1; start_valid = 1'b0; result_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0; c_in = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_start_ready", {31'd0, start_ready}, 32'd0);
    check("reset_result_valid", {31'd0, result_valid}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_sum", {16'd0, sum}, 32'd0);
    check("reset_flags", {30'd0, c_out, ovf}, 32'd0);
    rst = 1'b0;
    #1;
    check("start_ready_out_of_reset", {31'd0, start_ready}, 32'd1);

    op("add_basic", 16'h1234, 16'h0FCD, 1'b0, 1'b0);
    op("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    op("carry_in", 16'h0001, 16'h0001, 1'b0, 1'b1);
    op("signed_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1);
    op("sub_neg_ovf", 16'h8000, 16'h0001, 1'b1, 1'b0);
    op("sub_equal", 16'hA5A5, 16'hA5A5, 1'b1, 1'b0);

    // Backpressure: result held while a new start waits.
    start_op(16'h1234, 16'h0FCD, 1'b0, 1'b0);
    wait_result("bp_first", 16'h1234, 16'h0FCD, 1'b0, 1'b0);
    hold_sum = sum; hold_co = c_out; hold_ovf = ovf;
    start_valid = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0; c_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_sum_stable", {16'd0, sum}, {16'd0, hold_sum});
      check("bp_flags_stable", {30'd0, c_out, ovf}, {30'd0, hold_co, hold_ovf});
      check("bp_start_ready", {31'd0, start_ready}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("bp_rv_fall", {31'd0, result_valid}, 32'd0);
    check("bp_start_ready_rise", {31'd0, start_ready}, 32'd1);
    @(negedge clk);
    start_valid = 1'b0;
    check("bp_second_accepted", {31'd0, busy}, 32'd1);
    wait_result("bp_second", 16'h1111, 16'h2222, 1'b0, 1'b0);
    finish_op();

    // Reset after two RUN cycles discards the operation.
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_rv", {31'd0, result_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_sum", {16'd0, sum}, 32'd0);
    rst = 1'b0;
    repeat (N + 2) begin
      @(negedge clk);
      check("rst_no_stale_rv", {31'd0, result_valid}, 32'd0);
    end
    op("after_reset", 16'h00FF, 16'h0001, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      op("random", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder/subtractor that sequences a single internal 4-bit ripple-carry slice across the operand, one nibble per clock, LSB nibble first, with a registered carry fed back between nibbles. It sits between an operand producer and a result consumer and trades latency for area wherever a full-width adder is not justified. Operands enter through a valid/ready start handshake. Results leave through a valid/ready result handshake.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 8; N = WIDTH/4 nibbles.

- clk  input  1  sole clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start_valid  input  1  operands/opcode present
- start_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  1 = A − B, 0 = A + B + c_in
- c_in  input  1  carry-in for add; ignored when sub=1
- result_valid  output  1  sum/c_out/ovf hold a completed result
- result_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- c_out  output  1  carry out of MSB; for subtract, 1 = no borrow (A ≥ B unsigned)
- ovf  output  1  two's-complement overflow
- busy  output  1  high in RUN and DONE

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start_ready = 1. When start_valid = 1, the block accepts the operation at the clock edge:
  - a_q ← a.
  - b_q ← sub ? ~b : b.
  - carry ← sub ? 1 : c_in.
  - k ← 0.
  - Go to RUN.
- RUN: each cycle the slice adds nibble k, computing a_q[4k+3:4k] + b_q[4k+3:4k] + carry:
  - sum[4k+3:4k] ← slice sum.
  - carry ← slice carry-out.
  - k ← k+1.
  - When k = N−1:
    - c_out ← slice carry-out.
    - ovf ← (carry into bit WIDTH−1) XOR (carry out of bit WIDTH−1). The carry into bit WIDTH−1 is a_q[WIDTH−1] ^ b_q[WIDTH−1] ^ sum bit WIDTH−1.
    - Go to DONE.
- DONE: result_valid = 1. sum, c_out and ovf are held stable until result_valid·result_ready, then the FSM goes to IDLE.
- start_valid is ignored outside IDLE; operands are captured only at acceptance, so later changes on a/b/sub/c_in have no effect.
- sum, c_out and ovf retain the last result in IDLE. They are meaningful only while result_valid = 1.
- start_ready = (state == IDLE) && !rst.
- result_valid = (state == DONE).
- busy = (state != IDLE).
- k counter width: clog2(N), minimum 1. It never counts past N−1.

## Timing
- Reset (rst high at an edge, in any state, including mid-RUN and DONE):
  - state ← IDLE, k ← 0, carry ← 0.
  - a_q, b_q, sum ← 0; c_out, ovf ← 0.
  - The operation in flight is discarded; no result_valid is produced for it.
- Outputs after reset: start_ready = 1 (once rst low), result_valid = 0, busy = 0, sum = 0, c_out = 0, ovf = 0.
- Latency: acceptance at edge E0; RUN occupies edges E1..EN. result_valid is high in the cycle after EN, i.e. N cycles after acceptance (4 for WIDTH=16).
- Result handshake completes at the first edge with result_valid = 1 and result_ready = 1. start_ready is high in the following cycle.
- Minimum issue interval: N+2 cycles per operation.
- Simultaneous start_valid and result handshake in DONE: start is not accepted; it must be held until start_ready.
- result_ready asserted outside DONE has no effect.

## Test plan
- Add, WIDTH=16: a=0x1234, b=0x0FCD, sub=0, c_in=0 -> after 4 cycles: result_valid=1, sum=0x2201, c_out=0, ovf=0.
- Carry chain through all nibbles: a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1, ovf=0. Repeating a=0x0001, b=0x0001, c_in=1 -> sum=0x0003, c_out=0.
- Signed overflow: a=0x7FFF, b=0x0001 -> sum=0x8000, c_out=0, ovf=1. Subtract a=0x0005, b=0x0007, sub=1, c_in=1 -> sum=0xFFFE, c_out=0, ovf=0.
- Backpressure: complete an add, then hold result_ready=0 for 3 cycles while start_valid=1 with new operands -> sum/c_out/ovf stable, start_ready=0, busy=1. Raise result_ready -> result_valid falls next cycle, then the new operation is accepted.
- Reset mid-operation: accept a=0xFFFF, b=0x0001, then assert rst after 2 RUN cycles -> next cycle: state IDLE, result_valid=0, busy=0, sum=0. A following a=0x00FF, b=0x0001 completes with sum=0x0100 and no stale carry.
- Operand stability: change a/b/sub on every cycle during RUN -> result equals the operands captured at acceptance.
